// File: rtl/cordic_ahb_pkg.sv
// Shared encodings for the AHB-Lite CORDIC master.
//   - AHB-Lite HTRANS/HSIZE/HBURST/HPROT constants driven by the master.
//   - Master FSM state encoding. S_IDLE uses the same name as in the slave
//     wrapper's S_IDLE/S_READ/S_WRITE set.
//   - Width helper for the write-to-read latency counter.
package cordic_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_WADDR = 3'd1;
    localparam state_t S_WDATA = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_RADDR = 3'd4;
    localparam state_t S_RDATA = 3'd5;
    localparam state_t S_RESP  = 3'd6;

    // Counter must hold LATENCY itself; a zero latency still needs one bit.
    function automatic int unsigned lat_cnt_width(input int unsigned latency);
        return (latency == 0) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/cordic_ahb_latency_timer.sv
// Down-counter that spaces the operand write and the result read.
// Ports:
//   HCLK, HRESETn : clock, asynchronous active-low reset
//   load          : load the counter with LATENCY
//   en            : count down (master is waiting)
//   done          : high while enabled and the count has reached 1, i.e. in
//                   the last idle cycle before the read address phase
module cordic_ahb_latency_timer
    import cordic_ahb_pkg::*;
#(
    parameter int unsigned LATENCY = 16
) (
    input  logic HCLK,
    input  logic HRESETn,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam int unsigned   CW       = lat_cnt_width(LATENCY);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LATENCY);
    localparam logic [CW-1:0] LAST     = CW'(1);

    logic [CW-1:0] count;

    // NOTE: sequential state is written only with non-blocking assignments so
    // every flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign done = en && (count == LAST);

endmodule

// File: rtl/ahb_lite_cordic_master.sv
// AHB-Lite initiator for the CORDIC slave: writes one operand, waits LATENCY
// idle cycles, reads the result back and returns it on a valid/ready port.
// Ports:
//   HCLK, HRESETn           : bus clock, asynchronous active-low reset
//   HADDR/HTRANS/HWRITE/... : AHB-Lite master outputs (all registered)
//   HREADY, HRESP, HRDATA   : AHB-Lite slave-side returns
//   req_valid/ready/data    : operand command port
//   rsp_valid/ready/data/err: result port; rsp_data is 0 when rsp_err is set
module ahb_lite_cordic_master
    import cordic_ahb_pkg::*;
#(
    parameter logic [31:0] WR_ADDR = 32'h4000_0000,
    parameter logic [31:0] RD_ADDR = 32'h4000_0000,
    parameter int unsigned LATENCY = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [31:0] HRDATA,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam bit ZERO_LAT = (LATENCY == 0);

    state_t state;
    logic   timer_load;
    logic   timer_done;

    assign HBURST    = HBURST_SINGLE;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_DEFAULT;
    assign HSIZE     = HSIZE_WORD;

    // NOTE: req_ready is a continuous assign from state, so there is no
    // branch that can leave it unassigned and infer a latch.
    assign req_ready  = (state == S_IDLE);
    assign timer_load = (state == S_WDATA) && HREADY && !HRESP;

    cordic_ahb_latency_timer #(
        .LATENCY (LATENCY)
    ) u_timer (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .load    (timer_load),
        .en      (state == S_WAIT),
        .done    (timer_done)
    );

    // Bus outputs are updated on the same edge that enters the state they
    // belong to, so e.g. HTRANS is already NONSEQ during the first S_WADDR
    // cycle. HWDATA doubles as the operand holding register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state     <= S_IDLE;
            HTRANS    <= HTRANS_IDLE;
            HADDR     <= '0;
            HWRITE    <= 1'b0;
            HWDATA    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        HWDATA <= req_data;
                        HTRANS <= HTRANS_NONSEQ;
                        HADDR  <= WR_ADDR;
                        HWRITE <= 1'b1;
                        state  <= S_WADDR;
                    end
                end
                S_WADDR: begin
                    if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        state  <= S_WDATA;
                    end
                end
                S_WDATA: begin
                    // First ERROR cycle (HREADY low) simply waits here.
                    if (HREADY) begin
                        if (HRESP) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= S_RESP;
                        end else if (ZERO_LAT) begin
                            HTRANS <= HTRANS_NONSEQ;
                            HADDR  <= RD_ADDR;
                            HWRITE <= 1'b0;
                            state  <= S_RADDR;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (timer_done) begin
                        HTRANS <= HTRANS_NONSEQ;
                        HADDR  <= RD_ADDR;
                        HWRITE <= 1'b0;
                        state  <= S_RADDR;
                    end
                end
                S_RADDR: begin
                    if (HREADY) begin
                        HTRANS <= HTRANS_IDLE;
                        state  <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (HREADY) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= HRESP;
                        rsp_data  <= HRESP ? '0 : HRDATA;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    HTRANS <= HTRANS_IDLE;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_lite_cordic_master.sv
// Self-checking bench for ahb_lite_cordic_master: a reactive AHB-Lite slave
// model, a table of transactions and hand-written corner-case sequences.
module tb_ahb_lite_cordic_master;
    import cordic_ahb_pkg::*;

    localparam logic [31:0] WR_A = 32'h4000_0000;
    localparam logic [31:0] RD_A = 32'h4000_0004;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] HADDR, HWDATA, HRDATA, req_data, rsp_data;
    logic [2:0]  HBURST, HSIZE;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK, HWRITE, HREADY, HRESP;
    logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;

    // Second instance with LATENCY=0 and an always-ready slave.
    logic [31:0] z_haddr, z_hwdata, z_req_data, z_rsp_data;
    logic [2:0]  z_hburst, z_hsize;
    logic [3:0]  z_hprot;
    logic [1:0]  z_htrans;
    logic        z_hmastlock, z_hwrite, z_req_valid, z_req_ready;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic        z_hready = 1'b1;
    logic        z_hresp  = 1'b0;
    logic [31:0] z_hrdata = 32'h0BAD_F00D;

    always #5 HCLK = ~HCLK;

    ahb_lite_cordic_master #(.WR_ADDR(WR_A), .RD_ADDR(RD_A), .LATENCY(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HBURST(HBURST),
        .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HSIZE(HSIZE), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY), .HRESP(HRESP),
        .HRDATA(HRDATA), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err)
    );

    ahb_lite_cordic_master #(.LATENCY(0)) dut_z (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(z_haddr), .HBURST(z_hburst),
        .HMASTLOCK(z_hmastlock), .HPROT(z_hprot), .HSIZE(z_hsize), .HTRANS(z_htrans),
        .HWRITE(z_hwrite), .HWDATA(z_hwdata), .HREADY(z_hready), .HRESP(z_hresp),
        .HRDATA(z_hrdata), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_data(z_req_data), .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_data(z_rsp_data), .rsp_err(z_rsp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // ---------------- slave model ----------------
    int          ws_cfg = 0;
    bit          err_cfg = 1'b0;
    logic [31:0] rd_value = '0;
    logic        dp_active, dp_write;
    int          ws_left, err_left;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_active <= 1'b0;
            dp_write  <= 1'b0;
            ws_left   <= 0;
            err_left  <= 0;
        end else if (HTRANS == HTRANS_NONSEQ && HREADY) begin
            dp_active <= 1'b1;
            dp_write  <= HWRITE;
            ws_left   <= ws_cfg;
            err_left  <= err_cfg ? 2 : 0;
        end else if (dp_active) begin
            if (HREADY) begin
                dp_active <= 1'b0;
            end else begin
                if (ws_left > 0)  ws_left  <= ws_left - 1;
                if (err_left > 0) err_left <= err_left - 1;
            end
        end
    end

    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        if (dp_active) begin
            if (err_left != 0) begin
                HRESP  = 1'b1;
                HREADY = (err_left == 1);
            end else begin
                HREADY = (ws_left == 0);
            end
            if (!dp_write) HRDATA = rd_value;
        end
    end

    // ---------------- bus monitor ----------------
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [31:0] exp_op = '0;
    int          waddr_cyc, raddr_cyc, wd_cycles, hwdata_bad, nonseq_bad, addr_bad;

    always @(posedge HCLK) cyc <= cyc + 1;

    always @(negedge HCLK) begin
        if (HRESETn) begin
            if (HTRANS == HTRANS_NONSEQ) begin
                if (dp_active) nonseq_bad <= nonseq_bad + 1;
                if (HWRITE) begin
                    if (waddr_cyc < 0) waddr_cyc <= cyc - acc_cyc;
                    if (HADDR !== WR_A) addr_bad <= addr_bad + 1;
                end else begin
                    if (raddr_cyc < 0) raddr_cyc <= cyc - acc_cyc;
                    if (HADDR !== RD_A) addr_bad <= addr_bad + 1;
                end
            end else if (HTRANS !== HTRANS_IDLE) begin
                addr_bad <= addr_bad + 1;
            end
            if (dp_active && dp_write) begin
                wd_cycles <= wd_cycles + 1;
                if (HWDATA !== exp_op) hwdata_bad <= hwdata_bad + 1;
            end
        end
    end

    task automatic clear_trk();
        waddr_cyc = -1; raddr_cyc = -1; wd_cycles = 0;
        hwdata_bad = 0; nonseq_bad = 0; addr_bad = 0;
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [31:0] op;
        logic [31:0] rd;
        int          ws;
        bit          err;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_raddr;   // -1: no read may be issued
        int          exp_rsp;
        int          exp_wd;      // write data-phase length in cycles
    } vec_t;
    vec_t vecs[5];

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic send(input logic [31:0] op, input logic [31:0] e_data,
                        input logic e_err, output bit ok);
        ok = 1'b0;
        req_valid = 1'b1;
        req_data  = op;
        for (int i = 0; i < 50; i++) begin
            if (req_ready) begin
                acc_cyc = cyc;
                exp_q.push_back('{e_data, e_err});
                @(negedge HCLK);
                req_valid = 1'b0;
                req_data  = 32'hBAD0_BAD0;
                ok = 1'b1;
                return;
            end
            @(negedge HCLK);
        end
        req_valid = 1'b0;
        fail_bound("req_accept");
    endtask

    task automatic wait_rsp(output int rel, output bit ok);
        ok  = 1'b0;
        rel = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge HCLK);
            if (rsp_valid) begin
                rel = cyc - acc_cyc;
                ok  = 1'b1;
                return;
            end
        end
        fail_bound("rsp_valid");
    endtask

    task automatic take_rsp();
        exp_t e;
        if (exp_q.size() == 0) begin
            fail_bound("scoreboard_empty");
            return;
        end
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        rsp_ready = 1'b1;
        @(negedge HCLK);
        rsp_ready = 1'b0;
        check("rsp_valid_clear", {31'd0, rsp_valid}, 32'd0);
        check("req_ready_after_rsp", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        bit ok;
        int rel;
        ws_cfg = v.ws; err_cfg = v.err; rd_value = v.rd; exp_op = v.op;
        clear_trk();
        send(v.op, v.exp_data, v.exp_err, ok);
        if (!ok) return;
        wait_rsp(rel, ok);
        if (!ok) return;
        check("rsp_cycle", rel, v.exp_rsp);
        check("waddr_cycle", waddr_cyc, 1);
        check("raddr_cycle", raddr_cyc, v.exp_raddr);
        check("wdata_phase_len", wd_cycles, v.exp_wd);
        check("hwdata_stable", hwdata_bad, 0);
        check("no_overlap_nonseq", nonseq_bad, 0);
        check("haddr_htrans", addr_bad, 0);
        take_rsp();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        bit ok;
        int rel;
        int stall_bad;

        vecs[0] = '{32'h0001_0002, 32'h1234_5678, 0, 1'b0, 32'h1234_5678, 1'b0, 19, 21, 1};
        vecs[1] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 3, 1'b0, 32'hCAFE_F00D, 1'b0, 22, 27, 4};
        vecs[2] = '{32'h5555_AAAA, 32'h1111_1111, 0, 1'b1, 32'h0000_0000, 1'b1, -1, 4, 2};
        vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0000, 1, 1'b0, 32'h0000_0000, 1'b0, 20, 23, 2};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b0, 32'hFFFF_FFFF, 1'b0, 19, 21, 1};

        HRESETn = 1'b0;
        req_valid = 1'b0; req_data = '0; rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_data = '0; z_rsp_ready = 1'b0;
        clear_trk();
        repeat (3) @(negedge HCLK);

        // Reset state
        check("rst_htrans", {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
        check("rst_hwrite", {31'd0, HWRITE}, 32'd0);
        check("rst_haddr", HADDR, 32'd0);
        check("rst_hwdata", HWDATA, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("const_hburst", {29'd0, HBURST}, 32'd0);
        check("const_hsize", {29'd0, HSIZE}, 32'd2);
        check("const_hprot", {28'd0, HPROT}, 32'd3);
        check("const_hmastlock", {31'd0, HMASTLOCK}, 32'd0);
        HRESETn = 1'b1;
        @(negedge HCLK);

        // Table-driven transactions
        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // LATENCY=0: read NONSEQ directly after write data phase
        z_req_data = 32'h0F0F_1234;
        z_req_valid = 1'b1;
        check("z_req_ready", {31'd0, z_req_ready}, 32'd1);
        @(negedge HCLK);   // cycle 1
        z_req_valid = 1'b0;
        check("z_c1_htrans", {30'd0, z_htrans}, {30'd0, HTRANS_NONSEQ});
        check("z_c1_hwrite", {31'd0, z_hwrite}, 32'd1);
        @(negedge HCLK);   // cycle 2
        check("z_c2_htrans", {30'd0, z_htrans}, {30'd0, HTRANS_IDLE});
        check("z_c2_hwdata", z_hwdata, 32'h0F0F_1234);
        @(negedge HCLK);   // cycle 3
        check("z_c3_htrans", {30'd0, z_htrans}, {30'd0, HTRANS_NONSEQ});
        check("z_c3_hwrite", {31'd0, z_hwrite}, 32'd0);
        @(negedge HCLK);   // cycle 4
        check("z_c4_rsp_valid", {31'd0, z_rsp_valid}, 32'd0);
        @(negedge HCLK);   // cycle 5
        check("z_c5_rsp_valid", {31'd0, z_rsp_valid}, 32'd1);
        check("z_c5_rsp_data", z_rsp_data, 32'h0BAD_F00D);
        z_rsp_ready = 1'b1;
        @(negedge HCLK);
        z_rsp_ready = 1'b0;
        check("z_rsp_valid_clear", {31'd0, z_rsp_valid}, 32'd0);

        // Reset pulse during the latency wait aborts without a response
        ws_cfg = 0; err_cfg = 1'b0; rd_value = 32'h7777_7777; exp_op = 32'h2468_ACE0;
        clear_trk();
        send(32'h2468_ACE0, 32'h7777_7777, 1'b0, ok);
        void'(exp_q.pop_back());   // aborted: no response may appear
        repeat (6) @(negedge HCLK);
        HRESETn = 1'b0;
        #1;
        check("abort_htrans", {30'd0, HTRANS}, {30'd0, HTRANS_IDLE});
        check("abort_hwrite", {31'd0, HWRITE}, 32'd0);
        check("abort_haddr", HADDR, 32'd0);
        check("abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge HCLK);
        HRESETn = 1'b1;
        stall_bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge HCLK);
            if (rsp_valid) stall_bad++;
        end
        check("abort_no_rsp", stall_bad, 0);
        check("abort_no_read", raddr_cyc, 32'hFFFF_FFFF);
        check("abort_req_ready_after", {31'd0, req_ready}, 32'd1);
        run_vec(vecs[0]);

        // Response backpressure with a second request pending
        ws_cfg = 0; err_cfg = 1'b0; rd_value = 32'hA5A5_0001; exp_op = 32'h1357_9BDF;
        clear_trk();
        send(32'h1357_9BDF, 32'hA5A5_0001, 1'b0, ok);
        req_valid = 1'b1;
        req_data  = 32'h0246_8ACE;
        wait_rsp(rel, ok);
        check("bp_rsp_cycle", rel, 21);
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!rsp_valid || rsp_data !== 32'hA5A5_0001 || req_ready) stall_bad++;
            @(negedge HCLK);
        end
        check("bp_stall_stable", stall_bad, 0);
        rd_value = 32'hA5A5_0002;
        exp_op   = 32'h0246_8ACE;
        take_rsp();
        clear_trk();
        send(32'h0246_8ACE, 32'hA5A5_0002, 1'b0, ok);
        wait_rsp(rel, ok);
        check("bp2_rsp_cycle", rel, 21);
        check("bp2_hwdata_stable", hwdata_bad, 0);
        take_rsp();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
